// File: rtl/margin_seq_ctrl.sv
// Phase sequencer for the margin-sampling datapath: reads L samples from BRAM A,
// drains the margin pipeline, triggers the merge tree, and writes B entries to BRAM B.
module margin_seq_ctrl #(
    parameter int MAX_DATA_LENGTH       = 4608,
    parameter int MAX_BATCH_SIZE        = 512,
    parameter int MARGIN_PIPELINE_DEPTH = 3,
    parameter int N_REGISTERSBANKS      = 4,
    parameter int LEN_W                 = $clog2(MAX_DATA_LENGTH + 1),
    parameter int BAT_W                 = $clog2(MAX_BATCH_SIZE + 1),
    parameter int AW_A                  = $clog2(MAX_DATA_LENGTH),
    parameter int AW_B                  = $clog2(MAX_BATCH_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Abort,
    input  logic [LEN_W-1:0] CfgLength,
    input  logic [BAT_W-1:0] CfgBatch,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic             Aborted,
    output logic             CfgErr,
    output logic             EnA,
    output logic [AW_A-1:0]  AddrA,
    output logic             MrgnPipelineEn,
    output logic             MrgnSrc,
    output logic             IndxEn,
    output logic             TrigMTree,
    output logic             EnB,
    output logic [3:0]       WeB,
    output logic [AW_B-1:0]  AddrB,
    output logic [2:0]       Phase
);

    localparam int DEPTH = MARGIN_PIPELINE_DEPTH;
    localparam int CNT_W = (LEN_W > BAT_W) ? LEN_W : BAT_W;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW_A-1:0]  A_ONE    = {{(AW_A-1){1'b0}}, 1'b1};
    localparam logic [AW_B-1:0]  B_ONE    = {{(AW_B-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TREE_LAST  = CNT_W'(N_REGISTERSBANKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_TREE  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_r;
    logic [LEN_W-1:0]  len_r;
    logic [BAT_W-1:0]  bat_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DEPTH:0]    tok_r;
    logic              ready_r, busy_r, done_r, aborted_r, cfg_err_r;
    logic              en_a_r, pipe_en_r, src_r, trig_r, en_b_r;
    logic [AW_A-1:0]   addr_a_r;
    logic [AW_B-1:0]   addr_b_r;
    logic [3:0]        we_b_r;

    logic [CNT_W-1:0]  len_ext_s, bat_ext_s, len_last_s, bat_last_s;
    logic              cfg_bad_s;
    logic [DEPTH+1:0]  tok_shift_s;

    // Config legality check, phase end counts and next valid-token vector.
    always_comb begin
        len_ext_s   = CNT_W'(CfgLength);
        bat_ext_s   = CNT_W'(CfgBatch);
        cfg_bad_s   = (len_ext_s == CNT_ZERO) || (bat_ext_s == CNT_ZERO) || (bat_ext_s > len_ext_s);
        len_last_s  = CNT_W'(len_r) - CNT_ONE;
        bat_last_s  = CNT_W'(bat_r) - CNT_ONE;
        tok_shift_s = {tok_r, en_a_r};
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            len_r     <= '0;
            bat_r     <= '0;
            cnt_r     <= '0;
            tok_r     <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            cfg_err_r <= 1'b0;
            en_a_r    <= 1'b0;
            addr_a_r  <= '0;
            pipe_en_r <= 1'b0;
            src_r     <= 1'b1;
            trig_r    <= 1'b0;
            en_b_r    <= 1'b0;
            we_b_r    <= 4'h0;
            addr_b_r  <= '0;
        end else begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            cfg_err_r <= 1'b0;
            tok_r     <= tok_shift_s[DEPTH:0];
            // DONE finishes regardless of Abort; every other busy phase is cancelled.
            if (Abort && (state_r != S_IDLE) && (state_r != S_DONE)) begin
                state_r   <= S_IDLE;
                aborted_r <= 1'b1;
                tok_r     <= '0;
                cnt_r     <= '0;
                ready_r   <= 1'b1;
                busy_r    <= 1'b0;
                en_a_r    <= 1'b0;
                addr_a_r  <= '0;
                pipe_en_r <= 1'b0;
                src_r     <= 1'b1;
                trig_r    <= 1'b0;
                en_b_r    <= 1'b0;
                we_b_r    <= 4'h0;
                addr_b_r  <= '0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (Start && !Abort) begin
                            if (cfg_bad_s) begin
                                cfg_err_r <= 1'b1;
                            end else begin
                                state_r   <= S_READ;
                                len_r     <= CfgLength;
                                bat_r     <= CfgBatch;
                                cnt_r     <= '0;
                                ready_r   <= 1'b0;
                                busy_r    <= 1'b1;
                                en_a_r    <= 1'b1;
                                addr_a_r  <= '0;
                                pipe_en_r <= 1'b1;
                                src_r     <= 1'b0;
                            end
                        end
                    end
                    S_READ: begin
                        if (cnt_r == len_last_s) begin
                            state_r  <= S_DRAIN;
                            cnt_r    <= '0;
                            en_a_r   <= 1'b0;
                            addr_a_r <= '0;
                        end else begin
                            cnt_r    <= cnt_r + CNT_ONE;
                            addr_a_r <= addr_a_r + A_ONE;
                        end
                    end
                    S_DRAIN: begin
                        if (cnt_r == DRAIN_LAST) begin
                            state_r   <= S_TREE;
                            cnt_r     <= '0;
                            pipe_en_r <= 1'b0;
                            src_r     <= 1'b1;
                            trig_r    <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    S_TREE: begin
                        if (cnt_r == TREE_LAST) begin
                            state_r  <= S_WRITE;
                            cnt_r    <= '0;
                            trig_r   <= 1'b0;
                            en_b_r   <= 1'b1;
                            we_b_r   <= 4'hf;
                            addr_b_r <= '0;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    S_WRITE: begin
                        if (cnt_r == bat_last_s) begin
                            state_r  <= S_DONE;
                            cnt_r    <= '0;
                            en_b_r   <= 1'b0;
                            we_b_r   <= 4'h0;
                            addr_b_r <= '0;
                            done_r   <= 1'b1;
                        end else begin
                            cnt_r    <= cnt_r + CNT_ONE;
                            addr_b_r <= addr_b_r + B_ONE;
                        end
                    end
                    S_DONE: begin
                        state_r <= S_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        cnt_r     <= '0;
                        tok_r     <= '0;
                        ready_r   <= 1'b1;
                        busy_r    <= 1'b0;
                        en_a_r    <= 1'b0;
                        addr_a_r  <= '0;
                        pipe_en_r <= 1'b0;
                        src_r     <= 1'b1;
                        trig_r    <= 1'b0;
                        en_b_r    <= 1'b0;
                        we_b_r    <= 4'h0;
                        addr_b_r  <= '0;
                    end
                endcase
            end
        end
    end

    assign Ready          = ready_r;
    assign Busy           = busy_r;
    assign Done           = done_r;
    assign Aborted        = aborted_r;
    assign CfgErr         = cfg_err_r;
    assign EnA            = en_a_r;
    assign AddrA          = addr_a_r;
    assign MrgnPipelineEn = pipe_en_r;
    assign MrgnSrc        = src_r;
    assign IndxEn         = tok_r[DEPTH];
    assign TrigMTree      = trig_r;
    assign EnB            = en_b_r;
    assign WeB            = we_b_r;
    assign AddrB          = addr_b_r;
    assign Phase          = state_r;

endmodule

// File: tb/tb_margin_seq_ctrl.sv
// Directed bench for margin_seq_ctrl: per-cycle expected outputs are queued from a
// timing model when a run is launched and compared cycle by cycle.
module tb_margin_seq_ctrl;

    localparam int D = 3;
    localparam int N = 4;

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        done;
        logic        aborted;
        logic        cfg_err;
        logic        en_a;
        logic [12:0] addr_a;
        logic        pipe_en;
        logic        src;
        logic        indx;
        logic        trig;
        logic        en_b;
        logic [3:0]  we_b;
        logic [8:0]  addr_b;
        logic [2:0]  phase;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Abort;
    logic [12:0] CfgLength;
    logic [9:0]  CfgBatch;
    logic        Ready, Busy, Done, Aborted, CfgErr, EnA;
    logic [12:0] AddrA;
    logic        MrgnPipelineEn, MrgnSrc, IndxEn, TrigMTree, EnB;
    logic [3:0]  WeB;
    logic [8:0]  AddrB;
    logic [2:0]  Phase;

    exp_t obs_s;
    exp_t sb[$];
    int   compared;
    int   mismatched;

    margin_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort),
        .CfgLength(CfgLength), .CfgBatch(CfgBatch),
        .Ready(Ready), .Busy(Busy), .Done(Done), .Aborted(Aborted), .CfgErr(CfgErr),
        .EnA(EnA), .AddrA(AddrA), .MrgnPipelineEn(MrgnPipelineEn), .MrgnSrc(MrgnSrc),
        .IndxEn(IndxEn), .TrigMTree(TrigMTree), .EnB(EnB), .WeB(WeB), .AddrB(AddrB),
        .Phase(Phase)
    );

    assign obs_s = {Ready, Busy, Done, Aborted, CfgErr, EnA, AddrA, MrgnPipelineEn,
                    MrgnSrc, IndxEn, TrigMTree, EnB, WeB, AddrB, Phase};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t idle_rec(input logic cfg_err, input logic aborted);
        exp_t e;
        e = '0;
        e.ready   = 1'b1;
        e.src     = 1'b1;
        e.cfg_err = cfg_err;
        e.aborted = aborted;
        return e;
    endfunction

    // Expected outputs in cycle k of a run whose Start was accepted at edge 0.
    function automatic exp_t model(input int l, input int b, input int k);
        exp_t e;
        int d_end, t_end, w_end, done_c;
        d_end  = l + D + 1;
        t_end  = d_end + N;
        w_end  = t_end + b;
        done_c = w_end + 1;
        e = idle_rec(1'b0, 1'b0);
        if (k >= 1 && k <= done_c) begin
            e.ready = 1'b0;
            e.busy  = 1'b1;
        end
        if (k >= 1 && k <= l) begin
            e.en_a = 1'b1; e.addr_a = 13'(k - 1); e.pipe_en = 1'b1; e.src = 1'b0; e.phase = 3'd1;
        end else if (k > l && k <= d_end) begin
            e.pipe_en = 1'b1; e.src = 1'b0; e.phase = 3'd2;
        end else if (k > d_end && k <= t_end) begin
            e.trig = 1'b1; e.phase = 3'd3;
        end else if (k > t_end && k <= w_end) begin
            e.en_b = 1'b1; e.we_b = 4'hf; e.addr_b = 9'(k - t_end - 1); e.phase = 3'd4;
        end else if (k == done_c) begin
            e.done = 1'b1; e.phase = 3'd5;
        end
        e.indx = (k >= D + 2) && (k <= d_end);
        return e;
    endfunction

    task automatic check(input exp_t o, input exp_t e, input string tag);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push_run(input int l, input int b, input int first, input int last);
        for (int k = first; k <= last; k++) sb.push_back(model(l, b, k));
    endtask

    // Advance one cycle and compare mid-cycle against the oldest queued expectation.
    task automatic step(input string tag, input int c);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s_c%0d: observed empty scoreboard expected an entry", tag, c);
        end else begin
            e = sb.pop_front();
            check(obs_s, e, $sformatf("%s_c%0d", tag, c));
        end
    endtask

    task automatic run_plain(input int l, input int b, input string tag);
        int t;
        t = l + D + N + b + 2;
        CfgLength = 13'(l);
        CfgBatch  = 10'(b);
        Start     = 1'b1;
        push_run(l, b, 1, t + 1);
        for (int c = 1; c <= t + 1; c++) begin
            step(tag, c);
            Start = 1'b0;
        end
    endtask

    task automatic cfg_reject(input int l, input int b, input string tag);
        CfgLength = 13'(l);
        CfgBatch  = 10'(b);
        Start     = 1'b1;
        sb.push_back(idle_rec(1'b1, 1'b0));
        sb.push_back(idle_rec(1'b0, 1'b0));
        step(tag, 1);
        Start = 1'b0;
        step(tag, 2);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        Start      = 1'b0;
        Abort      = 1'b0;
        CfgLength  = 13'd0;
        CfgBatch   = 10'd0;
        repeat (2) @(negedge clk);
        check(obs_s, idle_rec(1'b0, 1'b0), "reset_state");
        rst_n = 1'b1;

        run_plain(8, 4, "s1");

        cfg_reject(4, 5, "rej_b_gt_l");
        cfg_reject(0, 1, "rej_l0");
        cfg_reject(4, 0, "rej_b0");

        // Start together with Abort in IDLE must not launch a run.
        CfgLength = 13'd8; CfgBatch = 10'd4; Start = 1'b1; Abort = 1'b1;
        sb.push_back(idle_rec(1'b0, 1'b0));
        sb.push_back(idle_rec(1'b0, 1'b0));
        step("start_abort_idle", 1);
        Start = 1'b0; Abort = 1'b0;
        step("start_abort_idle", 2);

        // Abort sampled in cycle 10 (DRAIN).
        CfgLength = 13'd8; CfgBatch = 10'd4; Start = 1'b1;
        push_run(8, 4, 1, 10);
        sb.push_back(idle_rec(1'b0, 1'b1));
        sb.push_back(idle_rec(1'b0, 1'b0));
        sb.push_back(idle_rec(1'b0, 1'b0));
        for (int c = 1; c <= 13; c++) begin
            step("abort_drain", c);
            Start = 1'b0;
            Abort = (c == 10);
        end

        // Second Start with a changed length mid-run is ignored.
        CfgLength = 13'd8; CfgBatch = 10'd4; Start = 1'b1;
        push_run(8, 4, 1, 22);
        for (int c = 1; c <= 22; c++) begin
            step("restart_ignored", c);
            Start = (c == 5);
            if (c == 5) CfgLength = 13'd2;
        end

        // L=1, B=1 with Abort held during DONE: Done still pulses, no Aborted.
        CfgLength = 13'd1; CfgBatch = 10'd1; Start = 1'b1;
        push_run(1, 1, 1, 13);
        for (int c = 1; c <= 13; c++) begin
            step("l1b1_abort_done", c);
            Start = 1'b0;
            Abort = (c == 11);
        end

        run_plain(6, 6, "b_eq_l");
        run_plain(4608, 512, "max_len");

        // Async reset during WRITE (cycle 18), then a clean rerun.
        CfgLength = 13'd8; CfgBatch = 10'd4; Start = 1'b1;
        push_run(8, 4, 1, 18);
        for (int c = 1; c <= 18; c++) begin
            step("pre_rst", c);
            Start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check(obs_s, idle_rec(1'b0, 1'b0), "async_reset_now");
        @(negedge clk);
        check(obs_s, idle_rec(1'b0, 1'b0), "async_reset_held");
        rst_n = 1'b1;
        run_plain(8, 4, "post_rst");

        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard_drained: observed %0d left expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/margin_seq_ctrl.md
Name: margin_seq_ctrl

Overview:
FSM-based sequencer for the margin-sampling datapath. It replaces the fixed single-counter controller with explicit phases and runtime-configurable data length and batch size, latched at start. It generates its own BRAM A read and BRAM B write addresses. It adds abort, done and configuration-error reporting. It sits between the host start/ready handshake and the margin pipeline, index counter, merge tree and output BRAM.

Parameters:
MAX_DATA_LENGTH, 4608, largest number of samples read from BRAM A per run
MAX_BATCH_SIZE, 512, largest number of selected entries written to BRAM B per run
MARGIN_PIPELINE_DEPTH, 3, register stages in margin pipeline after the 1-cycle BRAM read latency
N_REGISTERSBANKS, 4, number of cycles the merge tree must be triggered to reduce all banks
LEN_W, $clog2(MAX_DATA_LENGTH+1), width of CfgLength
BAT_W, $clog2(MAX_BATCH_SIZE+1), width of CfgBatch

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
Start  in  1  start request, sampled only while Ready=1
Abort  in  1  cancel current run
CfgLength  in  LEN_W  samples to read (L), latched on accepted Start
CfgBatch  in  BAT_W  entries to write (B), latched on accepted Start
Ready  out  1  1 in IDLE
Busy  out  1  1 in any state other than IDLE
Done  out  1  one-cycle pulse on normal completion
Aborted  out  1  one-cycle pulse when Abort terminates a run
CfgErr  out  1  one-cycle pulse when Start is rejected
EnA  out  1  BRAM A read enable
AddrA  out  $clog2(MAX_DATA_LENGTH)  BRAM A word address
MrgnPipelineEn  out  1  margin pipeline advance
MrgnSrc  out  1  0 = pipeline fed from BRAM, 1 = pipeline/registers held in init source
IndxEn  out  1  index counter / register-bank update enable, aligned to pipeline output
TrigMTree  out  1  merge-tree trigger
EnB  out  1  BRAM B enable
WeB  out  4  BRAM B byte write enables
AddrB  out  $clog2(MAX_BATCH_SIZE)  BRAM B word address
Phase  out  3  current state encoding for debug: IDLE=0 READ=1 DRAIN=2 TREE=3 WRITE=4 DONE=5

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - Ready=1, Phase=0, MrgnSrc=1.
  - All other outputs 0, including the delay shift register and latched config.
- IDLE, Start=1 and Abort=0:
  - Reject if L=0, B=0 or B>L: CfgErr=1 next cycle, stay IDLE, config not latched.
  - Otherwise latch L and B, go to READ.
- READ, L cycles:
  - EnA=1, AddrA=0..L-1 incrementing.
  - MrgnPipelineEn=1, MrgnSrc=0.
- DRAIN, MARGIN_PIPELINE_DEPTH+1 cycles:
  - MrgnPipelineEn=1, MrgnSrc=0, EnA=0.
- IndxEn:
  - Driven by a valid-token shift register of length MARGIN_PIPELINE_DEPTH+1 fed by EnA.
  - Therefore asserted exactly L cycles, starting MARGIN_PIPELINE_DEPTH+1 cycles after the first EnA cycle.
  - Last assertion falls on the final DRAIN cycle.
- TREE, N_REGISTERSBANKS cycles:
  - TrigMTree=1, MrgnSrc=1.
- WRITE, B cycles:
  - EnB=1, WeB=4'hf, AddrB=0..B-1.
- DONE, 1 cycle:
  - Done=1, then IDLE.
- Timing, with Start accepted at edge 0:
  - EnA in cycles 1..L.
  - Done in cycle L+D+N+B+2, where D=MARGIN_PIPELINE_DEPTH and N=N_REGISTERSBANKS.
  - Ready=1 again in cycle L+D+N+B+3.
- Outside their phases: EnA, EnB, WeB, TrigMTree, IndxEn are 0; AddrA and AddrB hold 0.
- Start while Busy is ignored. CfgLength/CfgBatch changes while Busy have no effect.
- Abort in any non-IDLE state:
  - Next cycle IDLE, Aborted=1 for one cycle.
  - All enables 0 and the token shift register cleared.
  - Done not asserted.
- Abort in IDLE is ignored; Abort together with Start in IDLE means Start is not accepted.
- Abort in DONE: Done still pulses, Aborted=0.
- Boundaries:
  - L=MAX_DATA_LENGTH: AddrA reaches MAX_DATA_LENGTH-1 with no wrap.
  - B=L is legal.
  - L=1: READ lasts 1 cycle and IndxEn is a single pulse.
- Async reset mid-run forces the reset values immediately. No Done or Aborted pulse is produced.

Test Plan:
- Defaults, L=8, B=4, Start at edge 0 -> EnA cycles 1–8 with AddrA 0..7; IndxEn cycles 5–12; TrigMTree cycles 13–16; EnB/WeB=f cycles 17–20 with AddrB 0..3; Done cycle 21; Ready cycle 22.
- Start with L=4, B=5 (also L=0, and B=0) -> CfgErr single pulse, Ready stays 1, no EnA.
- L=8, B=4, Abort asserted in cycle 10 (DRAIN) -> Aborted cycle 11, Ready cycle 11, IndxEn 0 from cycle 11, no TrigMTree, no Done.
- Second Start pulse at cycle 5 of a run with CfgLength changed to 2 -> ignored; timing identical to scenario 1.
- L=1, B=1 -> EnA cycle 1 only, IndxEn cycle 5, TrigMTree 6–9, EnB cycle 10, Done cycle 11.
- rst_n low during WRITE -> outputs return to reset values asynchronously; the next Start with L=8, B=4 reproduces scenario 1 timing.
